// File: rtl/lif_stream_loader.sv
// -----------------------------------------------------------------------------
// lif_stream_loader
//
// Host-side writer for the LIF neuron's byte-serial load interface. A request
// carries a full weight vector and input-spike vector. The loader streams them
// into the neuron one byte per cycle, most significant byte first. It then
// releases the neuron for RUN_CYCLES integration cycles, records the neuron's
// spike output as a spike train, and returns that train on a valid/ready
// response channel.
//
// Handshakes: a transfer happens on any rising edge where valid and ready are
// both high. Once raised, valid holds with stable payload until that edge.
// req_ready is high only while idle. rsp_valid rises when the spike train is
// complete and drops on the cycle after rsp_valid && rsp_ready.
//
// Optional build macro: LIF_LOADER_COUNT_EN adds rsp_count, the number of
// spikes in the returned train.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   req_valid / req_ready      request handshake
//   req_load_weights           1: send weights then inputs; 0: inputs only
//   req_weights, req_inputs    INPUTS-bit vectors, latched on accept
//   data_out, sel_weights      byte to the neuron and its weight/input target
//   load_mode                  1: neuron shifts bytes, membrane frozen
//   spike_in                   neuron spike output
//   rsp_valid / rsp_ready      response handshake
//   rsp_spikes                 bit k = spike_in during run cycle k
//   rsp_count                  (LIF_LOADER_COUNT_EN only) popcount of the train
//   busy                       high whenever not idle
//   state_dbg                  current FSM state encoding
// -----------------------------------------------------------------------------
module lif_stream_loader #(
  parameter int N_STAGES   = 5,
  parameter int RUN_CYCLES = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_load_weights,
  input  logic [2**N_STAGES-1:0]           req_weights,
  input  logic [2**N_STAGES-1:0]           req_inputs,
  output logic [7:0]                       data_out,
  output logic                             sel_weights,
  output logic                             load_mode,
  input  logic                             spike_in,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [RUN_CYCLES-1:0]            rsp_spikes,
`ifdef LIF_LOADER_COUNT_EN
  output logic [$clog2(RUN_CYCLES+1)-1:0]  rsp_count,
`endif
  output logic                             busy,
  output logic [2:0]                       state_dbg
);

  localparam int INPUTS = 2**N_STAGES;
  localparam int NB     = (INPUTS <= 8) ? 1 : INPUTS / 8;
  // Vectors are zero-padded to a whole number of bytes.
  localparam int VW     = NB * 8;
  localparam int BCW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int RCW    = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_I = 3'd2,
    RUN    = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [RCW-1:0]        run_cnt_q, run_cnt_d;
  logic [INPUTS-1:0]     w_q, w_d;
  logic [INPUTS-1:0]     i_q, i_d;
  logic [7:0]            data_out_q, data_out_d;
  logic                  sel_weights_q, sel_weights_d;
  logic                  load_mode_q, load_mode_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [RUN_CYCLES-1:0] rsp_spikes_q, rsp_spikes_d;
  logic                  busy_q, busy_d;
  logic                  req_ready_q, req_ready_d;
`ifdef LIF_LOADER_COUNT_EN
  logic [$clog2(RUN_CYCLES+1)-1:0] count_q, count_d;
`endif

  logic [INPUTS-1:0] vec_sel;
  logic [VW-1:0]     vec_pad;
  int                byte_idx;

  // Next-state and counter logic.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    run_cnt_d    = run_cnt_q;
    w_d          = w_q;
    i_d          = i_q;
    rsp_spikes_d = rsp_spikes_q;
`ifdef LIF_LOADER_COUNT_EN
    count_d      = count_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          w_d          = req_weights;
          i_d          = req_inputs;
          rsp_spikes_d = '0;
`ifdef LIF_LOADER_COUNT_EN
          count_d      = '0;
`endif
          byte_cnt_d   = '0;
          run_cnt_d    = '0;
          state_d      = req_load_weights ? LOAD_W : LOAD_I;
        end
      end
      LOAD_W: begin
        if (byte_cnt_q == BCW'(NB - 1)) begin
          byte_cnt_d = '0;
          state_d    = LOAD_I;
        end else begin
          byte_cnt_d = byte_cnt_q + BCW'(1);
        end
      end
      LOAD_I: begin
        if (byte_cnt_q == BCW'(NB - 1)) begin
          byte_cnt_d = '0;
          run_cnt_d  = '0;
          state_d    = RUN;
        end else begin
          byte_cnt_d = byte_cnt_q + BCW'(1);
        end
      end
      RUN: begin
        // The edge that ends run cycle k samples the neuron's spike into bit k.
        rsp_spikes_d[run_cnt_q] = spike_in;
`ifdef LIF_LOADER_COUNT_EN
        if (spike_in) count_d = count_q + $bits(count_q)'(1);
`endif
        if (run_cnt_q == RCW'(RUN_CYCLES - 1)) begin
          run_cnt_d = '0;
          state_d   = RESP;
        end else begin
          run_cnt_d = run_cnt_q + RCW'(1);
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state: the first
  // byte appears in the cycle right after the accept edge.
  always_comb begin
    vec_sel       = (state_d == LOAD_W) ? w_d : i_d;
    vec_pad       = VW'(vec_sel);
    byte_idx      = NB - 1 - int'(byte_cnt_d);
    data_out_d    = 8'h00;
    if (state_d == LOAD_W || state_d == LOAD_I) begin
      data_out_d = vec_pad[byte_idx*8 +: 8];
    end
    sel_weights_d = (state_d == LOAD_W);
    load_mode_d   = (state_d != RUN);
    rsp_valid_d   = (state_d == RESP);
    busy_d        = (state_d != IDLE);
    req_ready_d   = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      run_cnt_q     <= '0;
      w_q           <= '0;
      i_q           <= '0;
      data_out_q    <= 8'h00;
      sel_weights_q <= 1'b0;
      load_mode_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_spikes_q  <= '0;
      busy_q        <= 1'b0;
      req_ready_q   <= 1'b1;
`ifdef LIF_LOADER_COUNT_EN
      count_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      run_cnt_q     <= run_cnt_d;
      w_q           <= w_d;
      i_q           <= i_d;
      data_out_q    <= data_out_d;
      sel_weights_q <= sel_weights_d;
      load_mode_q   <= load_mode_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_spikes_q  <= rsp_spikes_d;
      busy_q        <= busy_d;
      req_ready_q   <= req_ready_d;
`ifdef LIF_LOADER_COUNT_EN
      count_q       <= count_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign data_out    = data_out_q;
  assign sel_weights = sel_weights_q;
  assign load_mode   = load_mode_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_spikes  = rsp_spikes_q;
  assign busy        = busy_q;
  assign state_dbg   = state_q;
`ifdef LIF_LOADER_COUNT_EN
  assign rsp_count   = count_q;
`endif

endmodule

// File: tb/tb_lif_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_lif_stream_loader: self-checking bench for lif_stream_loader with default
// parameters (32-bit vectors, 4 bytes per vector, 8 run cycles).
// -----------------------------------------------------------------------------
module tb_lif_stream_loader;

  localparam int W   = 32;
  localparam int NB  = 4;
  localparam int RUN = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_load_weights = 1'b0;
  logic [W-1:0]  req_weights = '0;
  logic [W-1:0]  req_inputs = '0;
  logic [7:0]    data_out;
  logic          sel_weights;
  logic          load_mode;
  logic          spike_in = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [RUN-1:0] rsp_spikes;
  logic          busy;
  logic [2:0]    state_dbg;
`ifdef LIF_LOADER_COUNT_EN
  logic [3:0]    rsp_count;
`endif

  lif_stream_loader dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_load_weights (req_load_weights),
    .req_weights      (req_weights),
    .req_inputs       (req_inputs),
    .data_out         (data_out),
    .sel_weights      (sel_weights),
    .load_mode        (load_mode),
    .spike_in         (spike_in),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_spikes       (rsp_spikes),
`ifdef LIF_LOADER_COUNT_EN
    .rsp_count        (rsp_count),
`endif
    .busy             (busy),
    .state_dbg        (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q[$];      // {sel_weights, data_out} per load byte
  logic [7:0] exp_rsp_q[$];  // spike train per response
  logic [3:0] exp_cnt_q[$];  // spike count per response

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    #2;
    if (busy && load_mode && !rsp_valid) begin
      if (exp_q.size() == 0) fail_now("unexpected_load_byte");
      else check("load_byte", {55'd0, sel_weights, data_out}, {55'd0, exp_q.pop_front()});
    end
    if (busy && !load_mode) check("run_bus_quiet", {55'd0, sel_weights, data_out}, 64'd0);
    if (rsp_valid && rsp_ready) begin
      if (exp_rsp_q.size() == 0) fail_now("unexpected_response");
      else begin
        check("rsp_spikes", {56'd0, rsp_spikes}, {56'd0, exp_rsp_q.pop_front()});
`ifdef LIF_LOADER_COUNT_EN
        if (exp_cnt_q.size() != 0) check("rsp_count", {60'd0, rsp_count}, {60'd0, exp_cnt_q.pop_front()});
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic         lw;
    logic [W-1:0] w;
    logic [W-1:0] i;
    logic [7:0]   pat;       // spike_in driven in run cycle k = pat[k]
    logic [7:0]   exp_sp;
    logic [3:0]   exp_cnt;
    int           exp_edges;
  } vec_t;

  task automatic push_exp(input logic lw, input logic [W-1:0] w, input logic [W-1:0] i,
                          input logic push_rsp, input logic [7:0] sp, input logic [3:0] cnt);
    if (lw) for (int b = NB - 1; b >= 0; b--) exp_q.push_back({1'b1, w[b*8 +: 8]});
    for (int b = NB - 1; b >= 0; b--) exp_q.push_back({1'b0, i[b*8 +: 8]});
    if (push_rsp) begin
      exp_rsp_q.push_back(sp);
      exp_cnt_q.push_back(cnt);
    end
  endtask

  // Called at a negedge with the request presented; returns #1 after accept edge.
  task automatic wait_accept();
    int g = 0;
    while (!req_ready && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (g >= 60) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    req_valid        = 1'b0;
    // Garbage outside the accept edge must be ignored.
    req_weights      = $urandom;
    req_inputs       = $urandom;
    req_load_weights = 1'($urandom_range(0, 1));
  endtask

  // Starts #1 after the accept edge; returns at the negedge after rsp_valid rose.
  task automatic run_txn(input logic [7:0] pat, input int exp_edges);
    int edges = 0;
    fork
      begin
        int g = 0;
        @(negedge clk);
        while (load_mode && g < 60) begin
          @(negedge clk);
          g++;
        end
        if (g >= 60) fail_now("run_phase_timeout");
        else begin
          for (int k = 0; k < RUN; k++) begin
            spike_in = pat[k];
            @(negedge clk);
          end
        end
        spike_in = 1'b0;
      end
      begin
        while (!rsp_valid && edges < 60) begin
          @(posedge clk);
          #1;
          edges++;
        end
      end
    join
    check("rsp_latency", 64'(edges), 64'(exp_edges));
  endtask

  task automatic do_req(input vec_t v);
    @(negedge clk);
    req_load_weights = v.lw;
    req_weights      = v.w;
    req_inputs       = v.i;
    req_valid        = 1'b1;
    push_exp(v.lw, v.w, v.i, 1'b1, v.exp_sp, v.exp_cnt);
    wait_accept();
    run_txn(v.pat, v.exp_edges);
    @(posedge clk);
    #1;
    check("post_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("post_rsp_busy", {63'd0, busy}, 64'd0);
    check("post_rsp_req_ready", {63'd0, req_ready}, 64'd1);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[5];
  vec_t hv;
  int   rv_seen;

  initial begin
    tbl[0] = '{1'b1, 32'h1234_5678, 32'hA5A5_00FF, 8'b1000_1101, 8'h8D, 4'd4, 16};
    tbl[1] = '{1'b0, 32'hDEAD_BEEF, 32'h0F1E_2D3C, 8'h00,        8'h00, 4'd0, 12};
    tbl[2] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 8'hFF,        8'hFF, 4'd8, 16};
    tbl[3] = '{1'b0, 32'h0000_0000, 32'h8000_0001, 8'h5A,        8'h5A, 4'd4, 12};
    tbl[4].lw        = 1'($urandom_range(0, 1));
    tbl[4].w         = $urandom;
    tbl[4].i         = $urandom;
    tbl[4].pat       = 8'($urandom_range(0, 255));
    tbl[4].exp_sp    = tbl[4].pat;
    tbl[4].exp_cnt   = 4'($countones(tbl[4].pat));
    tbl[4].exp_edges = tbl[4].lw ? 16 : 12;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_req_ready", {63'd0, req_ready}, 64'd1);
    check("reset_load_mode", {63'd0, load_mode}, 64'd1);
    check("reset_sel_weights", {63'd0, sel_weights}, 64'd0);
    check("reset_data_out", {56'd0, data_out}, 64'd0);
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_rsp_spikes", {56'd0, rsp_spikes}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_state", {61'd0, state_dbg}, 64'd0);

    // Table-driven transactions.
    for (int t = 0; t < 5; t++) do_req(tbl[t]);

    // Response held under back-pressure while the next request waits.
    hv = '{1'b1, 32'hCAFE_F00D, 32'h0102_0304, 8'b0110_0011, 8'h63, 4'd4, 16};
    @(negedge clk);
    rsp_ready        = 1'b0;
    req_load_weights = hv.lw;
    req_weights      = hv.w;
    req_inputs       = hv.i;
    req_valid        = 1'b1;
    push_exp(hv.lw, hv.w, hv.i, 1'b1, hv.exp_sp, hv.exp_cnt);
    wait_accept();
    run_txn(hv.pat, hv.exp_edges);
    req_load_weights = 1'b0;
    req_weights      = 32'h1111_2222;
    req_inputs       = 32'h3333_4444;
    req_valid        = 1'b1;
    push_exp(1'b0, 32'h1111_2222, 32'h3333_4444, 1'b1, 8'h00, 4'd0);
    for (int h = 0; h < 5; h++) begin
      check("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("hold_rsp_spikes", {56'd0, rsp_spikes}, {56'd0, hv.exp_sp});
      check("hold_load_mode", {63'd0, load_mode}, 64'd1);
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_rsp_dropped", {63'd0, rsp_valid}, 64'd0);
    check("b2b_idle_ready", {63'd0, req_ready}, 64'd1);
    check("b2b_idle_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    check("b2b_accepted_busy", {63'd0, busy}, 64'd1);
    check("b2b_accepted_ready", {63'd0, req_ready}, 64'd0);
    req_valid = 1'b0;
    run_txn(8'h00, 12);
    @(posedge clk);
    #1;
    check("b2b_post_rsp_valid", {63'd0, rsp_valid}, 64'd0);

    // Reset in the middle of the input load.
    @(negedge clk);
    req_load_weights = 1'b0;
    req_weights      = 32'h0;
    req_inputs       = 32'hF0E1_D2C3;
    req_valid        = 1'b1;
    push_exp(1'b0, 32'h0, 32'hF0E1_D2C3, 1'b0, 8'h00, 4'd0);
    wait_accept();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_state", {61'd0, state_dbg}, 64'd0);
    check("abort_load_mode", {63'd0, load_mode}, 64'd1);
    check("abort_data_out", {56'd0, data_out}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_bytes_left", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) rv_seen++;
    end
    check("abort_no_response", 64'(rv_seen), 64'd0);

    check("bytes_drained", 64'(exp_q.size()), 64'd0);
    check("responses_drained", 64'(exp_rsp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
